// File: rtl/regfile_dump_if.sv
// Valid/ready stream carrying one register-file word and its entry index.
// Master drives valid/data/index; slave drives ready.
interface regfile_dump_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic [ADDR_W:0]   index;

    modport master (
        output valid,
        output data,
        output index,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        input  index,
        output ready
    );
endinterface

// File: rtl/regfile_dump.sv
// Register-file snapshot engine: walks every entry and streams it out.
// Define REGFILE_DUMP_CHECKSUM_EN to append an XOR checksum word.
module regfile_dump #(
    parameter int NUM_REGS = 32,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              abort,
    output logic [ADDR_W-1:0] rf_addr,
    input  logic [DATA_W-1:0] rf_data,
    regfile_dump_if.master    dump,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_SEND,
`ifdef REGFILE_DUMP_CHECKSUM_EN
        S_CSUM,
`endif
        S_DONE
    } state_t;

    state_t            state;
    state_t            nxt;
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] data_q;
    logic [ADDR_W:0]   index_q;
    logic              hs;
`ifdef REGFILE_DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] acc;
`endif

    assign hs = dump.valid & dump.ready;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state   <= S_IDLE;
            idx     <= '0;
            data_q  <= '0;
            index_q <= '0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
            acc     <= '0;
`endif
        end else begin
            state <= nxt;
            if (state == S_IDLE && start && !abort) begin
                idx <= '0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
                acc <= '0;
`endif
            end
            if (state == S_READ && !abort) begin
                data_q  <= rf_data;
                index_q <= {1'b0, idx};
`ifdef REGFILE_DUMP_CHECKSUM_EN
                acc     <= acc ^ rf_data;
`endif
            end
            if (state == S_SEND && hs && !abort && idx != LAST)
                idx <= idx + ADDR_W'(1);
        end
    end

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE: if (start && !abort) nxt = S_READ;
            S_READ: nxt = S_SEND;
            S_SEND: begin
                if (hs) begin
                    if (idx == LAST)
`ifdef REGFILE_DUMP_CHECKSUM_EN
                        nxt = S_CSUM;
`else
                        nxt = S_DONE;
`endif
                    else
                        nxt = S_READ;
                end
            end
`ifdef REGFILE_DUMP_CHECKSUM_EN
            S_CSUM: if (hs) nxt = S_DONE;
`endif
            S_DONE: nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
        // abort wins over any same-cycle handshake
        if (abort && state != S_IDLE) nxt = S_IDLE;
    end

    always_comb begin
        rf_addr    = '0;
        dump.valid = 1'b0;
        dump.data  = data_q;
        dump.index = index_q;
        busy       = (state != S_IDLE);
        done       = 1'b0;
        case (state)
            S_READ: rf_addr = idx;
            S_SEND: begin
                rf_addr    = idx;
                dump.valid = 1'b1;
            end
`ifdef REGFILE_DUMP_CHECKSUM_EN
            S_CSUM: begin
                rf_addr    = idx;
                dump.valid = 1'b1;
                dump.data  = acc;
                dump.index = (ADDR_W+1)'(NUM_REGS);
            end
`endif
            S_DONE: done = 1'b1;
            default: ;
        endcase
    end

endmodule
